// File: rtl/parking_gate_ctrl.sv
// Entrance barrier controller: open/hold/close sequencing, occupancy count, full flag, deny alarm.
// Moore outputs one cycle after the input edge; no backpressure, pulses are consumed in the cycle they arrive.
module parking_gate_ctrl #(
    parameter int OPEN_TICKS = 8,
    parameter int HOLD_TICKS = 16,
    parameter int CAPACITY   = 7,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grant_in,
    input  logic             deny_in,
    input  logic             car_passed,
    input  logic             obstruction,
    input  logic             exit_event,
    output logic             motor_open,
    output logic             motor_close,
    output logic             gate_open,
    output logic             full,
    output logic [CNT_W-1:0] occupancy,
    output logic             alarm
);

    localparam int MAX_TICKS = (OPEN_TICKS > HOLD_TICKS) ? OPEN_TICKS : HOLD_TICKS;
    localparam int TMR_W     = $clog2(MAX_TICKS + 1);
    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_TICKS - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] occupancy_q, occupancy_d;
    logic [1:0]       deny_cnt_q, deny_cnt_d;
    logic             alarm_q, alarm_d;
    logic             grant_q, grant_d;
    logic             deny_q, deny_d;

    logic grant_rise;
    logic deny_rise;
    logic car_count;

    assign grant_rise = grant_in & ~grant_q;
    assign deny_rise  = deny_in & ~deny_q;
    assign grant_d    = grant_in;
    assign deny_d     = deny_in;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        car_count = 1'b0;
        case (state_q)
            ST_CLOSED: begin
                if (grant_rise && !full) begin
                    state_d = ST_OPENING;
                    timer_d = OPEN_LOAD;
                end
            end
            ST_OPENING: begin
                if (timer_q == '0) begin
                    state_d = ST_OPEN;
                    timer_d = HOLD_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_OPEN: begin
                // A car seen on the last hold cycle still counts.
                if (car_passed) begin
                    state_d   = ST_CLOSING;
                    timer_d   = OPEN_LOAD;
                    car_count = 1'b1;
                end else if (timer_q == '0) begin
                    state_d = ST_CLOSING;
                    timer_d = OPEN_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_CLOSING: begin
                if (obstruction) begin
                    state_d = ST_OPENING;
                    timer_d = OPEN_LOAD;
                end else if (timer_q == '0) begin
                    state_d = ST_CLOSED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_CLOSED;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        occupancy_d = occupancy_q;
        // Simultaneous entry and exit cancel, even at either saturation bound.
        if (car_count && exit_event) begin
            occupancy_d = occupancy_q;
        end else if (car_count) begin
            if (occupancy_q != CAP) occupancy_d = occupancy_q + CNT_W'(1);
        end else if (exit_event) begin
            if (occupancy_q != '0) occupancy_d = occupancy_q - CNT_W'(1);
        end
    end

    always_comb begin
        deny_cnt_d = deny_cnt_q;
        if (grant_rise) begin
            deny_cnt_d = 2'd0;
        end else if (deny_rise && deny_cnt_q != 2'd3) begin
            deny_cnt_d = deny_cnt_q + 2'd1;
        end
        alarm_d = (deny_cnt_d == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLOSED;
            timer_q     <= '0;
            occupancy_q <= '0;
            deny_cnt_q  <= 2'd0;
            alarm_q     <= 1'b0;
            grant_q     <= 1'b0;
            deny_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            occupancy_q <= occupancy_d;
            deny_cnt_q  <= deny_cnt_d;
            alarm_q     <= alarm_d;
            grant_q     <= grant_d;
            deny_q      <= deny_d;
        end
    end

    assign motor_open  = (state_q == ST_OPENING);
    assign motor_close = (state_q == ST_CLOSING);
    assign gate_open   = (state_q == ST_OPEN);
    assign full        = (occupancy_q == CAP);
    assign occupancy   = occupancy_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl; inputs driven and outputs sampled 1ns after each rising edge.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       grant_in;
    logic       deny_in;
    logic       car_passed;
    logic       obstruction;
    logic       exit_event;
    logic       motor_open;
    logic       motor_close;
    logic       gate_open;
    logic       full;
    logic [2:0] occupancy;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    parking_gate_ctrl #(
        .OPEN_TICKS(8),
        .HOLD_TICKS(16),
        .CAPACITY  (7),
        .CNT_W     (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .grant_in   (grant_in),
        .deny_in    (deny_in),
        .car_passed (car_passed),
        .obstruction(obstruction),
        .exit_event (exit_event),
        .motor_open (motor_open),
        .motor_close(motor_close),
        .gate_open  (gate_open),
        .full       (full),
        .occupancy  (occupancy),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {motor_open, motor_close, gate_open, full, alarm}
    function automatic logic [4:0] outs();
        return {motor_open, motor_close, gate_open, full, alarm};
    endfunction

    task automatic do_entry();
        grant_in = 1'b1;
        tick();
        grant_in = 1'b0;
        repeat (8) tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; grant_in = 1'b0; deny_in = 1'b0;
        car_passed = 1'b0; obstruction = 1'b0; exit_event = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (outs() !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs(), 5'b00000);
        end
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
    endtask

    task automatic test_open_car();
        grant_in = 1'b1;
        tick();
        grant_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outs() !== 5'b10000) begin
                errors++;
                $display("FAIL opening_cycle%0d: got %b expected %b", i, outs(), 5'b10000);
            end
            tick();
        end
        checks++;
        if (outs() !== 5'b00100) begin
            errors++;
            $display("FAIL open_reached: got %b expected %b", outs(), 5'b00100);
        end
        repeat (2) tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outs() !== 5'b01000) begin
                errors++;
                $display("FAIL closing_cycle%0d: got %b expected %b", i, outs(), 5'b01000);
            end
            tick();
        end
        checks++;
        if (outs() !== 5'b00000 || occupancy !== 3'd1) begin
            errors++;
            $display("FAIL closed_after_car: got %b occ %0d expected %b occ 1", outs(), occupancy, 5'b00000);
        end
    endtask

    task automatic test_hold_timeout();
        int n_open, n_gate, n_close;
        n_open = 0; n_gate = 0; n_close = 0;
        grant_in = 1'b1;
        tick();
        grant_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n_open  += int'(motor_open);
            n_gate  += int'(gate_open);
            n_close += int'(motor_close);
            tick();
        end
        checks++;
        if (n_open !== 8 || n_gate !== 16 || n_close !== 8) begin
            errors++;
            $display("FAIL hold_timeout_counts: got open %0d gate %0d close %0d expected 8 16 8", n_open, n_gate, n_close);
        end
        checks++;
        if (outs() !== 5'b00000 || occupancy !== 3'd1) begin
            errors++;
            $display("FAIL hold_timeout_end: got %b occ %0d expected %b occ 1", outs(), occupancy, 5'b00000);
        end
    endtask

    task automatic test_obstruction();
        int n_open;
        n_open = 0;
        grant_in = 1'b1;
        tick();
        grant_in = 1'b0;
        repeat (8) tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs() !== 5'b01000) begin
            errors++;
            $display("FAIL obstr_fourth_closing: got %b expected %b", outs(), 5'b01000);
        end
        obstruction = 1'b1;
        tick();
        obstruction = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_open += int'(motor_open && !motor_close);
            tick();
        end
        checks++;
        if (n_open !== 8 || outs() !== 5'b00100) begin
            errors++;
            $display("FAIL obstr_reopen: got open %0d state %b expected 8 %b", n_open, outs(), 5'b00100);
        end
        repeat (24) tick();
        checks++;
        if (outs() !== 5'b00000 || occupancy !== 3'd2) begin
            errors++;
            $display("FAIL obstr_end: got %b occ %0d expected %b occ 2", outs(), occupancy, 5'b00000);
        end
    endtask

    task automatic test_full();
        repeat (5) do_entry();
        checks++;
        if (occupancy !== 3'd7 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_reached: got occ %0d full %b expected 7 1", occupancy, full);
        end
        grant_in = 1'b1;
        tick();
        grant_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (motor_open !== 1'b0) begin
                errors++;
                $display("FAIL full_grant_ignored%0d: got motor_open %b expected 0", i, motor_open);
            end
            tick();
        end
        exit_event = 1'b1;
        tick();
        exit_event = 1'b0;
        checks++;
        if (occupancy !== 3'd6 || full !== 1'b0) begin
            errors++;
            $display("FAIL exit_from_full: got occ %0d full %b expected 6 0", occupancy, full);
        end
        grant_in = 1'b1;
        tick();
        grant_in = 1'b0;
        checks++;
        if (motor_open !== 1'b1) begin
            errors++;
            $display("FAIL grant_after_exit: got motor_open %b expected 1", motor_open);
        end
        repeat (8) tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        repeat (8) tick();
        exit_event = 1'b1;
        repeat (4) tick();
        exit_event = 1'b0;
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL refill_and_exit: got occ %0d expected 3", occupancy);
        end
    endtask

    task automatic test_car_exit_same();
        grant_in = 1'b1;
        tick();
        grant_in = 1'b0;
        repeat (8) tick();
        car_passed = 1'b1;
        exit_event = 1'b1;
        tick();
        car_passed = 1'b0;
        exit_event = 1'b0;
        checks++;
        if (occupancy !== 3'd3 || motor_close !== 1'b1) begin
            errors++;
            $display("FAIL car_exit_same: got occ %0d close %b expected 3 1", occupancy, motor_close);
        end
        repeat (8) tick();
    endtask

    task automatic test_deny_alarm();
        int n_open, n_gate;
        n_open = 0; n_gate = 0;
        for (int i = 0; i < 2; i++) begin
            deny_in = 1'b1;
            tick();
            deny_in = 1'b0;
            tick();
        end
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_after_two: got %b expected 0", alarm);
        end
        deny_in = 1'b1;
        tick();
        deny_in = 1'b0;
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_after_three: got %b expected 1", alarm);
        end
        grant_in = 1'b1;
        tick();
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_cleared: got %b expected 0", alarm);
        end
        for (int i = 0; i < 40; i++) begin
            n_open += int'(motor_open);
            n_gate += int'(gate_open);
            if (i == 19) grant_in = 1'b0;
            tick();
        end
        checks++;
        if (n_open !== 8 || n_gate !== 16 || outs() !== 5'b00000) begin
            errors++;
            $display("FAIL grant_held: got open %0d gate %0d state %b expected 8 16 %b", n_open, n_gate, outs(), 5'b00000);
        end
    endtask

    task automatic test_reset_mid();
        grant_in = 1'b1;
        tick();
        grant_in = 1'b0;
        tick();
        checks++;
        if (motor_open !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_opening: got %b expected 1", motor_open);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (outs() !== 5'b00000 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: got %b occ %0d expected %b occ 0", outs(), occupancy, 5'b00000);
        end
        exit_event = 1'b1;
        tick();
        exit_event = 1'b0;
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL exit_at_zero: got occ %0d expected 0", occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_open_car();
        test_hold_timeout();
        test_obstruction();
        test_full();
        test_car_exit_same();
        test_deny_alarm();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
